// File: rtl/adder_fifo_regs.sv
// Operand FIFO -> pipelined adder -> result FIFO register slave behind the CL AXI-lite decode.
// Optional macro ADDER_FIFO_SATURATE_EN: clamp sums to OPW bits and report sticky SAT in STATUS[24].
module adder_fifo_regs #(
    parameter int unsigned OPW          = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADD_LAT      = 1,
    parameter logic [31:0] OPERAND_ADDR = 32'h600,
    parameter logic [31:0] RESULT_ADDR  = 32'h604,
    parameter logic [31:0] STATUS_ADDR  = 32'h608,
    parameter logic [31:0] CTRL_ADDR    = 32'h60C,
    parameter logic [31:0] UNIMPL_VAL   = 32'hDEAD_BEEF
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n_sync,
    input  logic [31:0] wr_addr,
    input  logic        wready,
    input  logic [31:0] wdata,
    input  logic        arvalid_q,
    input  logic [31:0] araddr_q,
    input  logic        rready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        result_avail
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = OPW + 1;
    localparam int unsigned IW = 3;
    localparam logic [31:0] UDF_VAL = 32'hDEAD_0000;
    localparam logic [1:0]  RESP_OKAY = 2'd0;
    localparam logic [1:0]  RESP_SLVERR = 2'd2;

    logic [2*OPW-1:0] op_mem [DEPTH];
    logic [PW-1:0]    op_wr;
    logic [PW-1:0]    op_rd;
    logic [CW-1:0]    op_count;

    logic [SW-1:0]    res_mem [DEPTH];
    logic [PW-1:0]    res_wr;
    logic [PW-1:0]    res_rd;
    logic [CW-1:0]    res_count;

    logic [ADD_LAT-1:0] pipe_vld;
    logic [SW-1:0]      pipe_sum [ADD_LAT];

    logic op_ovf;
    logic res_udf;
    logic sat;

    logic          wr_op_c;
    logic          wr_ctrl_c;
    logic          flush_c;
    logic          clr_c;
    logic          op_full_c;
    logic          issue_c;
    logic          op_push_c;
    logic          op_drop_c;
    logic          rd_accept_c;
    logic          res_pop_c;
    logic          res_udf_c;
    logic          res_push_c;
    logic          sat_hit_c;
    logic [IW-1:0] inflight_c;
    logic [CW-1:0] res_count_n_c;
    logic [OPW-1:0] op_a_c;
    logic [OPW-1:0] op_b_c;
    logic [SW-1:0] sum_full_c;
    logic [SW-1:0] sum_c;
    logic [31:0]   status_c;
    logic [31:0]   rd_data_c;
    logic [1:0]    rd_resp_c;
    logic          unused_wdata;

    assign unused_wdata = ^wdata;

    // Pipeline occupancy, used both for credit and STATUS.
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < ADD_LAT; i++) begin
            inflight_c = inflight_c + IW'(pipe_vld[i]);
        end
    end

    // Write decode, issue credit and FIFO control.
    always_comb begin
        wr_op_c     = wready && (wr_addr == OPERAND_ADDR);
        wr_ctrl_c   = wready && (wr_addr == CTRL_ADDR);
        flush_c     = wr_ctrl_c && wdata[0];
        clr_c       = wr_ctrl_c && wdata[1];
        op_full_c   = (op_count == CW'(DEPTH));
        issue_c     = (op_count != '0) &&
                      ((32'(res_count) + 32'(inflight_c)) < 32'(DEPTH));
        // A same-cycle issue frees a slot, so a push into a full FIFO still lands.
        op_push_c   = wr_op_c && (!op_full_c || issue_c);
        op_drop_c   = wr_op_c && op_full_c && !issue_c;
        rd_accept_c = arvalid_q && !rvalid;
        res_pop_c   = rd_accept_c && (araddr_q == RESULT_ADDR) && (res_count != '0);
        res_udf_c   = rd_accept_c && (araddr_q == RESULT_ADDR) && (res_count == '0);
        res_push_c  = pipe_vld[ADD_LAT-1];
        res_count_n_c = res_count + CW'(res_push_c) - CW'(res_pop_c);
    end

    // Adder stage input.
    always_comb begin
        op_a_c     = op_mem[op_rd][OPW-1:0];
        op_b_c     = op_mem[op_rd][2*OPW-1:OPW];
        sum_full_c = SW'(op_a_c) + SW'(op_b_c);
`ifdef ADDER_FIFO_SATURATE_EN
        sat_hit_c  = issue_c && sum_full_c[OPW];
        sum_c      = sum_full_c[OPW] ? SW'({OPW{1'b1}}) : sum_full_c;
`else
        sat_hit_c  = 1'b0;
        sum_c      = sum_full_c;
`endif
    end

    // STATUS word and read-data mux, sampled at acceptance.
    always_comb begin
        status_c        = '0;
        status_c[7:0]   = 8'(op_count);
        status_c[15:8]  = 8'(res_count);
        status_c[16]    = op_full_c;
        status_c[17]    = (res_count == '0);
        status_c[18]    = op_ovf;
        status_c[19]    = res_udf;
        status_c[23:20] = 4'(inflight_c);
        status_c[24]    = sat;

        rd_data_c = UNIMPL_VAL;
        rd_resp_c = RESP_OKAY;
        if (araddr_q == RESULT_ADDR) begin
            if (res_count != '0) begin
                rd_data_c = 32'(res_mem[res_rd]);
            end else begin
                rd_data_c = UDF_VAL;
                rd_resp_c = RESP_SLVERR;
            end
        end else if (araddr_q == STATUS_ADDR) begin
            rd_data_c = status_c;
        end
    end

    // FIFO storage and adder data path carry no reset.
    always_ff @(posedge clk_main_a0) begin
        if (op_push_c) begin
            op_mem[op_wr] <= wdata[2*OPW-1:0];
        end
        if (res_push_c) begin
            res_mem[res_wr] <= pipe_sum[ADD_LAT-1];
        end
        pipe_sum[0] <= sum_c;
        for (int i = 1; i < ADD_LAT; i++) begin
            pipe_sum[i] <= pipe_sum[i-1];
        end
    end

    // Operand FIFO pointers.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            op_wr    <= '0;
            op_rd    <= '0;
            op_count <= '0;
        end else if (flush_c) begin
            op_wr    <= '0;
            op_rd    <= '0;
            op_count <= '0;
        end else begin
            if (op_push_c) begin
                op_wr <= op_wr + PW'(1);
            end
            if (issue_c) begin
                op_rd <= op_rd + PW'(1);
            end
            op_count <= op_count + CW'(op_push_c) - CW'(issue_c);
        end
    end

    // Adder valid pipeline; a flush kills everything in flight.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue_c && !flush_c;
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] && !flush_c;
            end
        end
    end

    // Result FIFO pointers and registered non-empty flag.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            res_wr       <= '0;
            res_rd       <= '0;
            res_count    <= '0;
            result_avail <= 1'b0;
        end else if (flush_c) begin
            res_wr       <= '0;
            res_rd       <= '0;
            res_count    <= '0;
            result_avail <= 1'b0;
        end else begin
            if (res_push_c) begin
                res_wr <= res_wr + PW'(1);
            end
            if (res_pop_c) begin
                res_rd <= res_rd + PW'(1);
            end
            res_count    <= res_count_n_c;
            result_avail <= (res_count_n_c != '0);
        end
    end

    // Sticky error bits; a new event beats a same-cycle CLR.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            op_ovf  <= 1'b0;
            res_udf <= 1'b0;
            sat     <= 1'b0;
        end else begin
            op_ovf  <= op_drop_c || (op_ovf && !clr_c);
            res_udf <= res_udf_c || (res_udf && !clr_c);
            sat     <= sat_hit_c || (sat && !clr_c);
        end
    end

    // Read response channel.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= '0;
        end else if (rd_accept_c) begin
            rvalid <= 1'b1;
            rdata  <= rd_data_c;
            rresp  <= rd_resp_c;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= '0;
        end
    end

endmodule

// File: tb/tb_adder_fifo_regs.sv
// Directed self-checking bench for adder_fifo_regs at default parameters.
// Expected sums follow ADDER_FIFO_SATURATE_EN when the bench is built with it.
module tb_adder_fifo_regs;

    localparam logic [31:0] OPERAND_ADDR = 32'h600;
    localparam logic [31:0] RESULT_ADDR  = 32'h604;
    localparam logic [31:0] STATUS_ADDR  = 32'h608;
    localparam logic [31:0] CTRL_ADDR    = 32'h60C;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_addr;
    logic        wready;
    logic [31:0] wdata;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic        rready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        result_avail;

    int n_tests = 0;
    int n_fail  = 0;

    adder_fifo_regs dut (
        .clk_main_a0     (clk),
        .rst_main_n_sync (rst_n),
        .wr_addr         (wr_addr),
        .wready          (wready),
        .wdata           (wdata),
        .arvalid_q       (arvalid_q),
        .araddr_q        (araddr_q),
        .rready          (rready),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .rresp           (rresp),
        .result_avail    (result_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected 4-bit operand sum for this build.
    function automatic logic [31:0] exp_sum(input int a, input int b);
        int s;
        s = a + b;
`ifdef ADDER_FIFO_SATURATE_EN
        if (s > 15) s = 15;
`endif
        return 32'(s);
    endfunction

    // All tasks enter and leave at a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        wready  = 1'b1;
        wr_addr = addr;
        wdata   = data;
        @(negedge clk);
        wready  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
        bit seen = 1'b0;
        data      = '0;
        resp      = '0;
        arvalid_q = 1'b1;
        araddr_q  = addr;
        rready    = 1'b1;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1'b1;
                data = rdata;
                resp = rresp;
            end
        end
        arvalid_q = 1'b0;
        if (!seen) check({tag, "_timeout"}, 32'(rvalid), 32'd1);
        else @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        do_read(tag, addr, d, r);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    logic [31:0] sat_bit;

    initial begin
`ifdef ADDER_FIFO_SATURATE_EN
        sat_bit = 32'h0100_0000;
`else
        sat_bit = 32'h0;
`endif
        rst_n     = 1'b0;
        wready    = 1'b0;
        wr_addr   = '0;
        wdata     = '0;
        arvalid_q = 1'b0;
        araddr_q  = '0;
        rready    = 1'b0;
        idle(2);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_rresp", 32'(rresp), 32'd0);
        check("reset_avail", 32'(result_avail), 32'd0);
        rst_n = 1'b1;
        idle(1);
        rd_check("reset_status", STATUS_ADDR, 32'h0002_0000, 2'd0);

        // Single operand pair 3 + 5.
        do_write(OPERAND_ADDR, 32'h0000_0053);
        idle(3);
        check("t1_avail", 32'(result_avail), 32'd1);
        rd_check("t1_result", RESULT_ADDR, 32'h0000_0008, 2'd0);
        rd_check("t1_status", STATUS_ADDR, 32'h0002_0000, 2'd0);
        check("t1_avail_after", 32'(result_avail), 32'd0);

        // Nine pairs: credit holds the ninth in the operand FIFO.
        for (int i = 0; i < 9; i++) do_write(OPERAND_ADDR, 32'(((i + 1) << 4) | i));
        idle(12);
        rd_check("t2_status", STATUS_ADDR, 32'h0000_0801, 2'd0);
        for (int i = 0; i < 9; i++) begin
            idle(3);
            rd_check($sformatf("t2_result%0d", i), RESULT_ADDR, exp_sum(i, i + 1), 2'd0);
        end
        do_write(CTRL_ADDR, 32'd2);
        rd_check("t2_status_end", STATUS_ADDR, 32'h0002_0000, 2'd0);

        // Underflow and sticky clear.
        rd_check("t3_udf", RESULT_ADDR, 32'hDEAD_0000, 2'd2);
        rd_check("t3_status", STATUS_ADDR, 32'h000A_0000, 2'd0);
        do_write(CTRL_ADDR, 32'd2);
        rd_check("t3_status_clr", STATUS_ADDR, 32'h0002_0000, 2'd0);
        rd_check("unimpl", 32'h0000_0610, 32'hDEAD_BEEF, 2'd0);
        rd_check("ctrl_read", CTRL_ADDR, 32'hDEAD_BEEF, 2'd0);

        // Stalled read holds data and pops exactly once.
        do_write(OPERAND_ADDR, 32'h0000_0021);
        do_write(OPERAND_ADDR, 32'h0000_0044);
        idle(6);
        arvalid_q = 1'b1;
        araddr_q  = RESULT_ADDR;
        rready    = 1'b0;
        @(negedge clk);
        check("t4_rvalid", 32'(rvalid), 32'd1);
        check("t4_rdata", rdata, 32'h0000_0003);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_rvalid%0d", i), 32'(rvalid), 32'd1);
            check($sformatf("t4_hold_rdata%0d", i), rdata, 32'h0000_0003);
        end
        arvalid_q = 1'b0;
        rready    = 1'b1;
        @(negedge clk);
        check("t4_drop_rvalid", 32'(rvalid), 32'd0);
        check("t4_drop_rdata", rdata, 32'd0);
        rd_check("t4_status", STATUS_ADDR, 32'h0000_0100, 2'd0);
        rd_check("t4_next", RESULT_ADDR, 32'h0000_0008, 2'd0);

        // Overflow of both FIFOs, then flush.
        for (int i = 0; i < 18; i++) do_write(OPERAND_ADDR, 32'h0000_0011);
        idle(8);
        rd_check("t5_status", STATUS_ADDR, 32'h0005_0808, 2'd0);
        do_write(CTRL_ADDR, 32'd1);
        check("t5_avail_flush", 32'(result_avail), 32'd0);
        rd_check("t5_status_flush", STATUS_ADDR, 32'h0006_0000, 2'd0);
        do_write(CTRL_ADDR, 32'd2);
        rd_check("t5_status_clr", STATUS_ADDR, 32'h0002_0000, 2'd0);

        // Largest operands: full carry or clamp.
        do_write(OPERAND_ADDR, 32'h0000_00FF);
        idle(4);
        rd_check("t6_result", RESULT_ADDR, exp_sum(15, 15), 2'd0);
        rd_check("t6_status", STATUS_ADDR, 32'h0002_0000 | sat_bit, 2'd0);

        // Reset during an outstanding read drops rvalid at once.
        do_write(OPERAND_ADDR, 32'h0000_0053);
        idle(4);
        arvalid_q = 1'b1;
        araddr_q  = RESULT_ADDR;
        rready    = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid_before", 32'(rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        arvalid_q = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        rd_check("rst_mid_status", STATUS_ADDR, 32'h0002_0000, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_fifo_regs.md
Name: adder_fifo_regs

Overview:
- Parametrised successor to the single-operand adder register slave.
- Sits behind the CL AXI-lite write/read decode.
- Host writes queue operand pairs in an input FIFO. A pipelined adder drains them into a result FIFO. Host reads pop results.
- Adds status, flush and sticky error reporting, so operands and results are no longer lost or overwritten between host accesses.

Parameters:
- OPW, 4: operand width in bits; 2*OPW <= 32.
- DEPTH, 8: entries per FIFO, power of two, >= 2.
- ADD_LAT, 1: adder pipeline stages, 1..4.
- OPERAND_ADDR, 32'h600: write pushes an operand pair.
- RESULT_ADDR, 32'h604: read pops a result.
- STATUS_ADDR, 32'h608: read-only status.
- CTRL_ADDR, 32'h60C: write-only control.
- UNIMPL_VAL, 32'hDEAD_BEEF: read data for undecoded addresses.

Ports:
- clk_main_a0 in 1: sole clock.
- rst_main_n_sync in 1: reset, asynchronous assert, active-low.
- wr_addr in 32: write address, qualified by wready.
- wready in 1: write strobe; one write per cycle when high.
- wdata in 32: write data.
- arvalid_q in 1: read request.
- araddr_q in 32: read address.
- rready in 1: host accepts read data.
- rvalid out 1: read data valid.
- rdata out 32: read data.
- rresp out 2: 0 OKAY, 2 SLVERR.
- result_avail out 1: result FIFO non-empty, registered.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- Clock is clk_main_a0; reset is rst_main_n_sync.

Reset:
- rvalid=0, rdata=0, rresp=0, result_avail=0.
- Both FIFOs empty, pipeline valids cleared, sticky bits 0.

Operand write:
- Trigger: wready && wr_addr==OPERAND_ADDR.
- Pushes {b=wdata[2*OPW-1:OPW], a=wdata[OPW-1:0]}.
- If the operand FIFO is full: write dropped, sticky OP_OVF set.

Control write:
- Trigger: wready && wr_addr==CTRL_ADDR.
- wdata[0] FLUSH: empty both FIFOs and kill in-flight pipeline entries next cycle.
- wdata[1] CLR: clear sticky bits.
- Only one write per cycle, so FLUSH and an operand push can never coincide.

Adder pipeline:
- Issues one operand pair per cycle when the operand FIFO is non-empty and res_count + inflight < DEPTH (credit rule; the result FIFO never overflows).
- sum = a + b, zero-extended, OPW+1 bits.
- Pushed into the result FIFO exactly ADD_LAT cycles after issue.
- Push and pop in the same cycle are legal on either FIFO, including when full (operand FIFO: pop frees the slot first) or empty (result FIFO: a read while empty returns the error below).

Read channel:
- A request is accepted when arvalid_q && !rvalid. Requests while rvalid=1 are ignored; the host holds arvalid_q.
- Next cycle: rvalid=1, and rdata/rresp hold until the rvalid && rready cycle. rvalid drops the cycle after that; rdata/rresp return to 0.
- RESULT_ADDR, non-empty: pop at acceptance; rdata = zero-extended sum, rresp=0.
- RESULT_ADDR, empty: rdata=32'hDEAD_0000, rresp=2, sticky RES_UDF set.
- STATUS_ADDR fields:
  - [7:0] op_count
  - [15:8] res_count
  - [16] op_full
  - [17] res_empty
  - [18] OP_OVF
  - [19] RES_UDF
  - [23:20] inflight
  - [31:24] 0
  - Counts are sampled at acceptance.
- Any other address: UNIMPL_VAL, rresp=0.

Simultaneous events:
- A flush in the same cycle as a result-read acceptance: the pop uses pre-flush contents; the FIFOs are empty after.
- CLR in the same cycle as a new overflow/underflow event: the set wins.

Reset mid-read: rvalid drops immediately (asynchronous); the popped result is lost.

Optional Feature:
Macro ADDER_FIFO_SATURATE_EN.
- Defined: sum clamps to the OPW-bit maximum (2^OPW-1), and STATUS[24] is sticky SAT, set whenever a clamp occurs and cleared by CLR.
- Undefined: full OPW+1-bit sum, STATUS[24] reads 0.

Test Plan:
Defaults apply unless stated.

1. Reset, then write OPERAND_ADDR wdata=32'h0000_0053, then read RESULT_ADDR after 3 cycles -> rdata=32'h0000_0008, rresp=0; STATUS then shows op_count=0, res_count=0, res_empty=1.
2. Push 9 pairs back-to-back with no reads -> result FIFO holds 8 entries. The 9th pair stays in the operand FIFO, so op_count=1, res_count=8, inflight=0, OP_OVF=0. Read 9 times -> sums returned in push order.
3. Read RESULT_ADDR with the result FIFO empty -> rdata=32'hDEAD_0000, rresp=2, STATUS[19]=1. Write CTRL=2 -> STATUS[19]=0.
4. Hold rready=0 for 5 cycles with arvalid_q asserted -> rvalid and rdata stable. Exactly one pop occurs, and the next result is intact.
5. Push 16 pairs with reads stalled -> the 17th and later writes are dropped and OP_OVF=1. Write CTRL=1 -> op_count=0, res_count=0, inflight=0.
6. Push 32'h0000_00FF -> without the macro rdata=32'h0000_001E. With ADDER_FIFO_SATURATE_EN, rdata=32'h0000_000F and STATUS[24]=1.
